// File: rtl/entropy_harvester_pkg.sv
// Shared types and constants for the TRNG entropy harvester slice.
package trng_pkg;

  typedef enum logic {
    VN_EMPTY      = 1'b0,
    VN_HAVE_FIRST = 1'b1
  } vn_state_e;

  localparam int unsigned          OVF_CNT_W = 16;
  localparam logic [OVF_CNT_W-1:0] OVF_MAX   = '1;

  function automatic logic [OVF_CNT_W-1:0] ovf_sat_inc(input logic [OVF_CNT_W-1:0] v);
    return (v == OVF_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/entropy_harvester_if.sv
// Valid/ready word delivery bus between the harvester and its consumer.
interface entropy_harvester_if #(
  parameter int unsigned WORD_W = 32
) ();
  logic [WORD_W-1:0] word_out;
  logic              word_valid;
  logic              word_ready;

  modport master (output word_out, output word_valid, input  word_ready);
  modport slave  (input  word_out, input  word_valid, output word_ready);
endinterface

// File: rtl/entropy_harvester_vn.sv
// Von Neumann corrector: pairs successive samples, emits first bit of unequal pairs.
module vn_debiaser
  import trng_pkg::*;
#(
  parameter int unsigned VN_EN = 1
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic clear,
  input  logic bit_in,
  input  logic bit_vld,
  output logic bit_out,
  output logic bit_out_vld
);

  vn_state_e state_q, state_d;
  logic      first_q, first_d;
  logic      pair_emit;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= VN_EMPTY;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    first_d   = first_q;
    pair_emit = 1'b0;
    if (clear) begin
      state_d = VN_EMPTY;
    end else if (bit_vld) begin
      case (state_q)
        VN_EMPTY: begin
          first_d = bit_in;
          state_d = VN_HAVE_FIRST;
        end
        VN_HAVE_FIRST: begin
          pair_emit = (first_q != bit_in);
          state_d   = VN_EMPTY;
        end
        default: state_d = VN_EMPTY;
      endcase
    end
  end

  // (0,1) -> 0 and (1,0) -> 1, i.e. the stored first bit
  assign bit_out     = (VN_EN != 0) ? first_q   : bit_in;
  assign bit_out_vld = (VN_EN != 0) ? pair_emit : bit_vld;

endmodule

// File: rtl/entropy_harvester.sv
// Raw entropy synchroniser/XOR combiner, VN corrector, repetition-count test and word packer.
module entropy_harvester
  import trng_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned VN_EN       = 1,
  parameter int unsigned RCT_LIMIT   = 32
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [NUM_CH-1:0]    raw_bits,
  entropy_harvester_if.master  bus,
  output logic [OVF_CNT_W-1:0] overflow_cnt,
  output logic                 health_fail
);

  localparam int unsigned CNT_W = $clog2(WORD_W + 1);
  localparam int unsigned RCT_W = $clog2(RCT_LIMIT + 1);

  logic [NUM_CH-1:0]    sync_q [SYNC_STAGES];
  logic                 comb_q;
  logic [WORD_W-1:0]    shreg_q, shreg_d;
  logic [CNT_W-1:0]     bitcnt_q, bitcnt_d;
  logic [RCT_W-1:0]     rct_q, rct_d;
  logic                 last_q, last_d;
  logic                 hf_q, hf_d;
  logic [WORD_W-1:0]    word_q, word_d;
  logic                 valid_q, valid_d;
  logic [OVF_CNT_W-1:0] ovf_q, ovf_d;
  logic                 taken, vn_bit, vn_vld, complete;
  logic [WORD_W-1:0]    next_word;

  // Synchroniser and combiner free-run regardless of enable
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      comb_q <= 1'b0;
    end else begin
      sync_q[0] <= raw_bits;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      comb_q <= ^sync_q[SYNC_STAGES-1];
    end
  end

  assign taken = enable & ~hf_q;

  vn_debiaser #(.VN_EN(VN_EN)) u_vn (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .clear       (~enable),
    .bit_in      (comb_q),
    .bit_vld     (taken),
    .bit_out     (vn_bit),
    .bit_out_vld (vn_vld)
  );

  assign next_word = {shreg_q[WORD_W-2:0], vn_bit};

  always_comb begin
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    rct_d    = rct_q;
    last_d   = last_q;
    hf_d     = hf_q;
    word_d   = word_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    complete = 1'b0;
    if (!enable) begin
      shreg_d  = '0;
      bitcnt_d = '0;
      rct_d    = '0;
      hf_d     = 1'b0;
    end else begin
      if (taken) begin
        last_d = comb_q;
        rct_d  = (rct_q != '0 && comb_q == last_q) ? rct_q + 1'b1 : RCT_W'(1);
        if (rct_d >= RCT_W'(RCT_LIMIT)) hf_d = 1'b1;
      end
      if (vn_vld) begin
        shreg_d = next_word;
        if (bitcnt_q == CNT_W'(WORD_W - 1)) begin
          bitcnt_d = '0;
          complete = 1'b1;
        end else begin
          bitcnt_d = bitcnt_q + 1'b1;
        end
      end
    end
    // A completed word displaces the held one only if it is free or being consumed now
    if (complete) begin
      if (!valid_q || bus.word_ready) begin
        word_d  = next_word;
        valid_d = 1'b1;
      end else begin
        ovf_d = ovf_sat_inc(ovf_q);
      end
    end else if (valid_q && bus.word_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q  <= '0;
      bitcnt_q <= '0;
      rct_q    <= '0;
      last_q   <= 1'b0;
      hf_q     <= 1'b0;
      word_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= '0;
    end else begin
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      rct_q    <= rct_d;
      last_q   <= last_d;
      hf_q     <= hf_d;
      word_q   <= word_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.word_out   = word_q;
  assign bus.word_valid = valid_q;
  assign overflow_cnt   = ovf_q;
  assign health_fail    = hf_q;

endmodule

// File: tb/tb_entropy_harvester.sv
// Directed bench: one harvester with VN bypassed (u0) and one with VN enabled (u1).
module tb_entropy_harvester;
  import trng_pkg::*;

  logic                 clk;
  logic                 rst_n;
  logic                 enable;
  logic [1:0]           raw_bits;
  logic                 ready;
  logic [OVF_CNT_W-1:0] ovf0, ovf1;
  logic                 hf0, hf1;

  int checks   = 0;
  int failures = 0;

  // Samples are expressed in the comb_bit domain; run_seq skews enable by 3 cycles
  logic       samp_b [64];
  logic       samp_e [64];
  logic       vld0_l [64];
  logic       vld1_l [64];
  logic       hf0_l  [64];
  logic [7:0] out0_l [64];
  logic [7:0] out1_l [64];

  entropy_harvester_if #(.WORD_W(8)) if0 ();
  entropy_harvester_if #(.WORD_W(8)) if1 ();
  assign if0.word_ready = ready;
  assign if1.word_ready = ready;

  entropy_harvester #(.NUM_CH(2), .SYNC_STAGES(2), .WORD_W(8), .VN_EN(0), .RCT_LIMIT(16)) u0 (
    .clk_in(clk), .rst_n(rst_n), .enable(enable), .raw_bits(raw_bits),
    .bus(if0), .overflow_cnt(ovf0), .health_fail(hf0));

  entropy_harvester #(.NUM_CH(2), .SYNC_STAGES(2), .WORD_W(8), .VN_EN(1), .RCT_LIMIT(16)) u1 (
    .clk_in(clk), .rst_n(rst_n), .enable(enable), .raw_bits(raw_bits),
    .bus(if1), .overflow_cnt(ovf1), .health_fail(hf1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run_seq(input int len);
    for (int t = 0; t < len + 4; t++) begin
      raw_bits = {1'b0, (t < len) ? samp_b[t] : 1'b0};
      enable   = (t >= 3 && t - 3 < len) ? samp_e[t-3] : 1'b0;
      @(posedge clk);
      @(negedge clk);
      vld0_l[t] = if0.word_valid;
      vld1_l[t] = if1.word_valid;
      out0_l[t] = if0.word_out;
      out1_l[t] = if1.word_out;
      hf0_l[t]  = hf0;
    end
    enable = 1'b0;
  endtask

  task automatic test_reset();
    ready = 1'b0;
    for (int i = 0; i < 12; i++) begin samp_b[i] = 1'b1; samp_e[i] = 1'b1; end
    run_seq(12);
    checks++;
    if (if0.word_valid !== 1'b1) begin
      failures++; $display("FAIL pre_reset_valid got=%b exp=1", if0.word_valid);
    end
    checks++;
    if (if0.word_out !== 8'hFF) begin
      failures++; $display("FAIL pre_reset_word got=%h exp=ff", if0.word_out);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({if0.word_valid, if1.word_valid} !== 2'b00) begin
      failures++; $display("FAIL reset_valid got=%b%b exp=00", if0.word_valid, if1.word_valid);
    end
    checks++;
    if ({if0.word_out, if1.word_out} !== 16'h0000) begin
      failures++; $display("FAIL reset_word got=%h/%h exp=00/00", if0.word_out, if1.word_out);
    end
    checks++;
    if ({ovf0, ovf1} !== 32'h0) begin
      failures++; $display("FAIL reset_ovf got=%h/%h exp=0", ovf0, ovf1);
    end
    checks++;
    if ({hf0, hf1} !== 2'b00) begin
      failures++; $display("FAIL reset_hf got=%b%b exp=00", hf0, hf1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_bypass_pack();
    logic [7:0] s;
    s = 8'hA5;
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin samp_b[i] = s[7-i]; samp_e[i] = 1'b1; end
    run_seq(8);
    checks++;
    if (vld0_l[9] !== 1'b0) begin
      failures++; $display("FAIL bypass_early_valid got=%b exp=0", vld0_l[9]);
    end
    checks++;
    if (vld0_l[10] !== 1'b1 || out0_l[10] !== 8'hA5) begin
      failures++; $display("FAIL bypass_word got=%b/%h exp=1/a5", vld0_l[10], out0_l[10]);
    end
    checks++;
    if (vld0_l[11] !== 1'b0) begin
      failures++; $display("FAIL bypass_valid_one_cycle got=%b exp=0", vld0_l[11]);
    end
  endtask

  task automatic test_vn();
    logic [19:0] s;
    s = 20'b10_01_11_10_10_00_01_01_10_01;
    ready = 1'b1;
    for (int i = 0; i < 20; i++) begin samp_b[i] = s[19-i]; samp_e[i] = 1'b1; end
    run_seq(20);
    checks++;
    if (vld1_l[21] !== 1'b0) begin
      failures++; $display("FAIL vn_early_valid got=%b exp=0", vld1_l[21]);
    end
    checks++;
    if (vld1_l[22] !== 1'b1 || out1_l[22] !== 8'hB2) begin
      failures++; $display("FAIL vn_word got=%b/%h exp=1/b2", vld1_l[22], out1_l[22]);
    end
  endtask

  task automatic test_backpressure();
    ready = 1'b0;
    for (int i = 0; i < 24; i++) begin samp_b[i] = (i % 2 == 0); samp_e[i] = 1'b1; end
    run_seq(24);
    checks++;
    if (vld0_l[10] !== 1'b1 || out0_l[10] !== 8'hAA) begin
      failures++; $display("FAIL bp_first_word got=%b/%h exp=1/aa", vld0_l[10], out0_l[10]);
    end
    checks++;
    if (if0.word_out !== 8'hAA || if0.word_valid !== 1'b1) begin
      failures++; $display("FAIL bp_hold got=%b/%h exp=1/aa", if0.word_valid, if0.word_out);
    end
    checks++;
    if (ovf0 !== 16'd2) begin
      failures++; $display("FAIL bp_overflow got=%0d exp=2", ovf0);
    end
    ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ready = 1'b0;
    checks++;
    if (if0.word_valid !== 1'b0) begin
      failures++; $display("FAIL bp_drain got=%b exp=0", if0.word_valid);
    end
  endtask

  task automatic test_health();
    ready = 1'b1;
    for (int i = 0; i < 25; i++) begin
      samp_b[i] = (i < 4) ? (i % 2 == 0) : 1'b1;
      samp_e[i] = (i < 24);
    end
    run_seq(25);
    checks++;
    if (vld0_l[10] !== 1'b1 || out0_l[10] !== 8'hAF) begin
      failures++; $display("FAIL hf_word1 got=%b/%h exp=1/af", vld0_l[10], out0_l[10]);
    end
    checks++;
    if (vld0_l[18] !== 1'b1 || out0_l[18] !== 8'hFF) begin
      failures++; $display("FAIL hf_word2 got=%b/%h exp=1/ff", vld0_l[18], out0_l[18]);
    end
    checks++;
    if (hf0_l[21] !== 1'b0 || hf0_l[22] !== 1'b1) begin
      failures++; $display("FAIL hf_rise got=%b%b exp=01", hf0_l[21], hf0_l[22]);
    end
    checks++;
    if (vld0_l[26] !== 1'b0 || hf0_l[26] !== 1'b1) begin
      failures++; $display("FAIL hf_freeze got=valid %b hf %b exp=valid 0 hf 1", vld0_l[26], hf0_l[26]);
    end
    checks++;
    if (hf0_l[27] !== 1'b0) begin
      failures++; $display("FAIL hf_clear got=%b exp=0", hf0_l[27]);
    end
  endtask

  task automatic test_enable_flush();
    logic [13:0] s;
    s = 14'b11111_0_11000011;
    ready = 1'b1;
    for (int i = 0; i < 14; i++) begin samp_b[i] = s[13-i]; samp_e[i] = (i != 5); end
    run_seq(14);
    checks++;
    if (vld0_l[11] !== 1'b0 || vld0_l[15] !== 1'b0) begin
      failures++; $display("FAIL flush_residue got=%b%b exp=00", vld0_l[11], vld0_l[15]);
    end
    checks++;
    if (vld0_l[16] !== 1'b1 || out0_l[16] !== 8'hC3) begin
      failures++; $display("FAIL flush_word got=%b/%h exp=1/c3", vld0_l[16], out0_l[16]);
    end
    checks++;
    if (ovf0 !== 16'd2) begin
      failures++; $display("FAIL flush_overflow got=%0d exp=2", ovf0);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    enable   = 1'b0;
    raw_bits = '0;
    ready    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_bypass_pack();
    test_vn();
    test_backpressure();
    test_health();
    test_enable_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
